conv_lb_sched: RTL and testbench
================================

# conv_lb_sched

Line-buffer scheduler for the 5x5 convolution datapath. Tracks frame and line position of the incoming pixel stream, rotates the write target through the five line buffers on each end of line, and issues per-pixel write and read enables plus the column address. Reports the window-centre position once a full 5x5 neighbourhood is available. Sits between the pixel input interface and the line-buffer array, alongside the convolution controller.

## Interface
- LINE_W_MAX, 2048: maximum pixels per line; column counter width is CW = $clog2(LINE_W_MAX).
- ROW_W, 12: row counter width.
- clk  in  1  clock; all state updates on rising edge.
- arst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- intf_vld_i  in  1  pixel valid; every valid beat is accepted (no backpressure).
- intf_sof_i  in  1  start of frame; qualified by intf_vld_i.
- intf_eol_i  in  1  last pixel of line; qualified by intf_vld_i.
- lbx_we_o  out  5  one-hot line-buffer write enable, combinational.
- lbx_re_o  out  5  line-buffer read enable mask, combinational.
- lb_addr_o  out  CW  column address for the current beat, combinational.
- lbx_nl_o  out  1  registered one-cycle pulse after each line end.
- wr_ptr_o  out  3  current write line buffer index, 0..4.
- primed_o  out  3  number of buffered previous lines, 0..4.
- pos_vld_o  out  1  registered: full window available.
- pos_row_o  out  ROW_W  window-centre row (row-2).
- pos_col_o  out  CW  window-centre column (col-2).
- err_o  out  1  registered one-cycle protocol error pulse.

## Operation
- States: IDLE (no frame open), ACTIVE (frame open). Reset enters IDLE.
- Beat B = intf_vld_i. Start S = B & intf_sof_i. S is valid in either state and restarts the frame in the same cycle. Effective values for that beat are col=0, row=0, wr_ptr=0, primed=0, width unlatched. State goes to ACTIVE.
- B without sof in IDLE: beat is dropped. No enables are driven. err_o pulses.
- Accepted beat, meaning ACTIVE or S:
  - lbx_we_o = 1<<wr_ptr.
  - lb_addr_o = col.
  - lbx_re_o has bits (wr_ptr-k) mod 5 set for k = 1..primed.
  - With no accepted beat, lbx_we_o, lbx_re_o and lb_addr_o are 0.
- Line end L is either:
  - an accepted beat with intf_eol_i, or
  - an accepted beat at col = LINE_W_MAX-1 without eol. This forced end also pulses err_o.
- On L:
  - col goes to 0 and row increments (wraps at 2^ROW_W).
  - wr_ptr goes to (wr_ptr+1) mod 5.
  - primed saturates at 4.
  - lbx_nl_o pulses the next cycle.
  - On the first line of a frame, width is latched as col+1.
  - On later lines, if col+1 differs from width, err_o pulses. The line is still accepted.
- Other accepted beats: col increments.
- Window: pos_vld_o is asserted for an accepted beat with row >= 4 and col >= 4, using the values before update. pos_row_o = row-2 and pos_col_o = col-2.
- S and eol on the same beat: a one-pixel first line. width=1. The rotation happens.
- No frame-end marker exists. A frame stays ACTIVE until the next sof.

## Timing
- lbx_we_o, lbx_re_o and lb_addr_o are combinational in the same cycle as the beat, so the line-buffer write and read occur at that clock edge.
- pos_vld_o, pos_row_o, pos_col_o, lbx_nl_o and err_o have 1-cycle latency from the beat. pos_vld_o is 1 only for that one cycle.
- wr_ptr_o and primed_o reflect registered state after the update.
- Reset values:
  - state = IDLE.
  - All outputs = 0.
  - col, row, width, wr_ptr and primed = 0.
- arst_n asserted mid-line: all state clears immediately. The first beat after release must carry sof, otherwise it is dropped with err_o.
- Back-to-back beats are sustained at 1 per cycle, including an eol followed directly by the next line's pixel 0.

## Test plan
- Reset, then a 6x8 frame with sof on pixel 0 and eol on col 7:
  - lbx_we_o sequence is 01,02,04,08,10,01 per line.
  - primed_o reaches 4 after line 4.
  - pos_vld_o asserts first for row 4 col 4, with pos_row_o=2 and pos_col_o=2. It asserts 8 times in total: cols 4..7 on rows 4 and 5.
  - err_o is never asserted.
- On the row-4 beat with wr_ptr=4: lbx_re_o=0F, and lb_addr_o tracks col 0..7.
- Beat without sof after reset: lbx_we_o=0, err_o pulses once, state stays IDLE.
- Line 2 ends at col 5 when width is 8: err_o pulses, rotation still occurs, lbx_nl_o pulses.
- sof mid-line on row 3 col 2: same cycle lbx_we_o=01, lbx_re_o=0, col restarts at 0.
- LINE_W_MAX=8 with no eol: the col-7 beat forces a line end, err_o pulses, wr_ptr advances. arst_n pulse mid-frame returns all outputs to 0.

Source files
------------

// File: rtl/conv_lb_sched_if.sv
// Pixel-stream and line-buffer control bundle for conv_lb_sched.
// The pixel source drives the three stream qualifiers; everything else is scheduler output.
interface conv_lb_sched_if #(
   parameter int CW    = 11,
   parameter int ROW_W = 12
);
   logic             intf_vld_i;
   logic             intf_sof_i;
   logic             intf_eol_i;
   logic [4:0]       lbx_we_o;
   logic [4:0]       lbx_re_o;
   logic [CW-1:0]    lb_addr_o;
   logic             lbx_nl_o;
   logic [2:0]       wr_ptr_o;
   logic [2:0]       primed_o;
   logic             pos_vld_o;
   logic [ROW_W-1:0] pos_row_o;
   logic [CW-1:0]    pos_col_o;
   logic             err_o;

   modport master (
      output intf_vld_i, intf_sof_i, intf_eol_i,
      input  lbx_we_o, lbx_re_o, lb_addr_o, lbx_nl_o, wr_ptr_o, primed_o,
      input  pos_vld_o, pos_row_o, pos_col_o, err_o
   );

   modport slave (
      input  intf_vld_i, intf_sof_i, intf_eol_i,
      output lbx_we_o, lbx_re_o, lb_addr_o, lbx_nl_o, wr_ptr_o, primed_o,
      output pos_vld_o, pos_row_o, pos_col_o, err_o
   );
endinterface

// File: rtl/conv_lb_sched.sv
// Line-buffer scheduler for the 5x5 convolution: frame/line tracking, write-buffer
// rotation, per-beat buffer enables and window-centre reporting.
module conv_lb_sched #(
   parameter int LINE_W_MAX = 2048,
   parameter int ROW_W      = 12
) (
   input logic            clk,
   input logic            arst_n,
   conv_lb_sched_if.slave bus
);
   localparam int CW = $clog2(LINE_W_MAX);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    col_reg, col_next;
   logic [ROW_W-1:0] row_reg, row_next;
   logic [CW:0]      width_reg, width_next;
   logic             width_vld_reg, width_vld_next;
   logic [2:0]       ptr_reg, ptr_next;
   logic [2:0]       primed_reg, primed_next;
   logic             nl_reg, nl_next;
   logic             err_reg, err_next;
   logic             pos_vld_reg, pos_vld_next;
   logic [ROW_W-1:0] pos_row_reg, pos_row_next;
   logic [CW-1:0]    pos_col_reg, pos_col_next;

   logic             start;
   logic             accept;
   logic             line_end;
   logic [CW-1:0]    eff_col;
   logic [ROW_W-1:0] eff_row;
   logic [2:0]       eff_ptr;
   logic [2:0]       eff_primed;
   logic             eff_wvld;
   logic [CW:0]      col_plus1;
   logic [4:1][4:0]  re_term;
   logic [4:0]       re_mask;

   // A sof beat restarts the frame in its own cycle, so it sees zeroed position state.
   assign start      = bus.intf_vld_i & bus.intf_sof_i;
   assign accept     = bus.intf_vld_i & (start | (state_reg == ACTIVE));
   assign eff_col    = start ? '0 : col_reg;
   assign eff_row    = start ? '0 : row_reg;
   assign eff_ptr    = start ? '0 : ptr_reg;
   assign eff_primed = start ? '0 : primed_reg;
   assign eff_wvld   = start ? 1'b0 : width_vld_reg;
   assign col_plus1  = {1'b0, eff_col} + 1'b1;
   assign line_end   = accept & (bus.intf_eol_i | (eff_col == CW'(LINE_W_MAX - 1)));

   // Bit k of the read mask marks the buffer written k lines ago, k = 1..primed.
   genvar gi;
   generate
      for (gi = 1; gi <= 4; gi++) begin : g_re
         logic [2:0] idx;
         assign idx = (eff_ptr >= 3'(gi)) ? (eff_ptr - 3'(gi)) : (eff_ptr + 3'(5 - gi));
         assign re_term[gi] = (eff_primed >= 3'(gi)) ? (5'b00001 << idx) : 5'b00000;
      end
   endgenerate
   assign re_mask = re_term[1] | re_term[2] | re_term[3] | re_term[4];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_reg     <= IDLE;
         col_reg       <= '0;
         row_reg       <= '0;
         width_reg     <= '0;
         width_vld_reg <= 1'b0;
         ptr_reg       <= '0;
         primed_reg    <= '0;
         nl_reg        <= 1'b0;
         err_reg       <= 1'b0;
         pos_vld_reg   <= 1'b0;
         pos_row_reg   <= '0;
         pos_col_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         col_reg       <= col_next;
         row_reg       <= row_next;
         width_reg     <= width_next;
         width_vld_reg <= width_vld_next;
         ptr_reg       <= ptr_next;
         primed_reg    <= primed_next;
         nl_reg        <= nl_next;
         err_reg       <= err_next;
         pos_vld_reg   <= pos_vld_next;
         pos_row_reg   <= pos_row_next;
         pos_col_reg   <= pos_col_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      col_next       = col_reg;
      row_next       = row_reg;
      width_next     = width_reg;
      width_vld_next = width_vld_reg;
      ptr_next       = ptr_reg;
      primed_next    = primed_reg;
      nl_next        = 1'b0;
      err_next       = 1'b0;
      pos_vld_next   = 1'b0;
      pos_row_next   = pos_row_reg;
      pos_col_next   = pos_col_reg;
      bus.lbx_we_o   = '0;
      bus.lbx_re_o   = '0;
      bus.lb_addr_o  = '0;

      // Pixels arriving before any sof have no frame to belong to.
      if (bus.intf_vld_i && !accept) begin
         err_next = 1'b1;
      end

      if (accept) begin
         state_next     = ACTIVE;
         bus.lbx_we_o   = 5'b00001 << eff_ptr;
         bus.lbx_re_o   = re_mask;
         bus.lb_addr_o  = eff_col;
         row_next       = eff_row;
         ptr_next       = eff_ptr;
         primed_next    = eff_primed;
         width_vld_next = eff_wvld;
         width_next     = start ? '0 : width_reg;

         if ((eff_row >= ROW_W'(4)) && (eff_col >= CW'(4))) begin
            pos_vld_next = 1'b1;
            pos_row_next = eff_row - ROW_W'(2);
            pos_col_next = eff_col - CW'(2);
         end

         if (line_end) begin
            col_next    = '0;
            row_next    = eff_row + 1'b1;
            ptr_next    = (eff_ptr == 3'd4) ? 3'd0 : eff_ptr + 3'd1;
            primed_next = (eff_primed == 3'd4) ? 3'd4 : eff_primed + 3'd1;
            nl_next     = 1'b1;
            if (!bus.intf_eol_i) begin
               err_next = 1'b1;
            end
            // The first line of a frame defines the width; later lines are only checked.
            if (!eff_wvld) begin
               width_next     = col_plus1;
               width_vld_next = 1'b1;
            end else if (col_plus1 != width_reg) begin
               err_next = 1'b1;
            end
         end else begin
            col_next = eff_col + 1'b1;
         end
      end
   end

   assign bus.lbx_nl_o  = nl_reg;
   assign bus.err_o     = err_reg;
   assign bus.wr_ptr_o  = ptr_reg;
   assign bus.primed_o  = primed_reg;
   assign bus.pos_vld_o = pos_vld_reg;
   assign bus.pos_row_o = pos_row_reg;
   assign bus.pos_col_o = pos_col_reg;
endmodule

// File: tb/tb_conv_lb_sched.sv
// Bench for conv_lb_sched with LINE_W_MAX=8: directed table, scripted frames and a
// randomized stream checked against a line-history reference model.
module tb_conv_lb_sched;
   localparam int LW = 8;
   localparam int CW = 3;
   localparam int RW = 12;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   conv_lb_sched_if #(.CW(CW), .ROW_W(RW)) bus ();

   conv_lb_sched #(.LINE_W_MAX(LW), .ROW_W(RW)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame state as plain integers plus a history of written buffers.
   int m_active, m_col, m_row, m_width, m_lines;
   int hist[$];
   int e_we, e_re, e_addr, e_err, e_nl, e_pv, e_prow, e_pcol, e_ptr, e_primed;

   task automatic model_reset();
      m_active = 0; m_col = 0; m_row = 0; m_width = -1; m_lines = 0;
      hist.delete();
   endtask

   task automatic model_beat(input bit v, input bit s, input bit e);
      e_we = 0; e_re = 0; e_addr = 0; e_err = 0; e_nl = 0; e_pv = 0; e_prow = 0; e_pcol = 0;
      if (v && s) begin
         m_active = 1; m_col = 0; m_row = 0; m_width = -1; m_lines = 0;
         hist.delete();
      end
      if (v && !m_active) e_err = 1;
      if (v && m_active) begin
         e_we = 1 << (m_lines % 5);
         foreach (hist[i]) e_re |= (1 << hist[i]);
         e_addr = m_col;
         if (m_row >= 4 && m_col >= 4) begin
            e_pv = 1; e_prow = (m_row - 2) % (1 << RW); e_pcol = m_col - 2;
         end
         if (e || m_col == LW - 1) begin
            if (!e) e_err = 1;
            if (m_width < 0) m_width = m_col + 1;
            else if (m_col + 1 != m_width) e_err = 1;
            e_nl = 1;
            hist.push_back(m_lines % 5);
            if (hist.size() > 4) void'(hist.pop_front());
            m_lines++;
            m_col = 0;
            m_row = (m_row + 1) % (1 << RW);
         end else begin
            m_col++;
         end
      end
      e_ptr = m_lines % 5;
      e_primed = hist.size();
   endtask

   logic [4:0] obs_we, obs_re;
   logic [2:0] obs_addr;
   int seen_pv, seen_err, first_prow, first_pcol;

   // Called at posedge+1: drive a beat, check enables mid-cycle, then registered results.
   task automatic step(input bit v, input bit s, input bit e);
      bus.intf_vld_i = v; bus.intf_sof_i = s; bus.intf_eol_i = e;
      model_beat(v, s, e);
      @(negedge clk);
      obs_we = bus.lbx_we_o; obs_re = bus.lbx_re_o; obs_addr = bus.lb_addr_o;
      chk("we", 32'(bus.lbx_we_o), 32'(e_we));
      chk("re", 32'(bus.lbx_re_o), 32'(e_re));
      chk("addr", 32'(bus.lb_addr_o), 32'(e_addr));
      @(posedge clk); #1;
      chk("err", 32'(bus.err_o), 32'(e_err));
      chk("nl", 32'(bus.lbx_nl_o), 32'(e_nl));
      chk("pos_vld", 32'(bus.pos_vld_o), 32'(e_pv));
      chk("wr_ptr", 32'(bus.wr_ptr_o), 32'(e_ptr));
      chk("primed", 32'(bus.primed_o), 32'(e_primed));
      if (e_pv != 0) begin
         chk("pos_row", 32'(bus.pos_row_o), 32'(e_prow));
         chk("pos_col", 32'(bus.pos_col_o), 32'(e_pcol));
      end
      if (bus.pos_vld_o) begin
         if (seen_pv == 0) begin
            first_prow = int'(bus.pos_row_o); first_pcol = int'(bus.pos_col_o);
         end
         seen_pv++;
      end
      if (bus.err_o) seen_err++;
   endtask

   task automatic line(input int n, input bit sof0, input bit eol_last);
      for (int c = 0; c < n; c++) step(1'b1, sof0 && c == 0, eol_last && c == n - 1);
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {bus.lbx_we_o, bus.lbx_re_o, 5'(bus.lb_addr_o), bus.lbx_nl_o, bus.wr_ptr_o,
                 bus.primed_o, bus.pos_vld_o, bus.err_o, 4'(bus.pos_col_o)}, 32'd0);
      chk({name, "_row"}, 32'(bus.pos_row_o), 32'd0);
   endtask

   typedef struct {
      bit v, s, e;
      logic [4:0] we, re;
      logic [2:0] addr;
      bit err, nl;
      logic [2:0] ptr, primed;
   } vec_t;
   vec_t tbl[8];

   logic [4:0] exp_sol[6];
   logic [4:0] got_sol[6];

   initial begin
      tbl[0] = '{1, 0, 0, 5'h00, 5'h00, 3'd0, 1, 0, 3'd0, 3'd0};
      tbl[1] = '{0, 0, 0, 5'h00, 5'h00, 3'd0, 0, 0, 3'd0, 3'd0};
      tbl[2] = '{1, 1, 1, 5'h01, 5'h00, 3'd0, 0, 1, 3'd1, 3'd1};
      tbl[3] = '{1, 0, 0, 5'h02, 5'h01, 3'd0, 0, 0, 3'd1, 3'd1};
      tbl[4] = '{1, 0, 1, 5'h02, 5'h01, 3'd1, 1, 1, 3'd2, 3'd2};
      tbl[5] = '{1, 1, 0, 5'h01, 5'h00, 3'd0, 0, 0, 3'd0, 3'd0};
      tbl[6] = '{0, 0, 0, 5'h00, 5'h00, 3'd0, 0, 0, 3'd0, 3'd0};
      tbl[7] = '{1, 0, 1, 5'h01, 5'h00, 3'd1, 0, 1, 3'd1, 3'd1};
      exp_sol = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01};

      bus.intf_vld_i = 1'b0; bus.intf_sof_i = 1'b0; bus.intf_eol_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) arst_n = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("reset_state");

      // Directed table: dropped beat, one-pixel line, width mismatch, restart.
      for (int i = 0; i < 8; i++) begin
         bus.intf_vld_i = tbl[i].v; bus.intf_sof_i = tbl[i].s; bus.intf_eol_i = tbl[i].e;
         @(negedge clk);
         chk($sformatf("tbl%0d_we", i), 32'(bus.lbx_we_o), 32'(tbl[i].we));
         chk($sformatf("tbl%0d_re", i), 32'(bus.lbx_re_o), 32'(tbl[i].re));
         chk($sformatf("tbl%0d_addr", i), 32'(bus.lb_addr_o), 32'(tbl[i].addr));
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_err", i), 32'(bus.err_o), 32'(tbl[i].err));
         chk($sformatf("tbl%0d_nl", i), 32'(bus.lbx_nl_o), 32'(tbl[i].nl));
         chk($sformatf("tbl%0d_ptr", i), 32'(bus.wr_ptr_o), 32'(tbl[i].ptr));
         chk($sformatf("tbl%0d_primed", i), 32'(bus.primed_o), 32'(tbl[i].primed));
      end

      // Back to reset, then the 6x8 reference frame.
      arst_n = 1'b0; bus.intf_vld_i = 1'b0;
      @(negedge clk) arst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
      seen_pv = 0; seen_err = 0; first_prow = -1; first_pcol = -1;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 8; c++) begin
            step(1'b1, r == 0 && c == 0, c == 7);
            if (c == 0) got_sol[r] = obs_we;
            if (r == 4) chk($sformatf("row4_addr%0d", c), 32'(obs_addr), 32'(c));
            if (r == 4 && c == 0) chk("row4_re", 32'(obs_re), 32'h0F);
         end
         if (r == 3) chk("primed_after_line4", 32'(bus.primed_o), 32'd4);
      end
      for (int r = 0; r < 6; r++) chk($sformatf("sol_we%0d", r), 32'(got_sol[r]), 32'(exp_sol[r]));
      chk("pv_count", 32'(seen_pv), 32'd8);
      chk("first_prow", 32'(first_prow), 32'd2);
      chk("first_pcol", 32'(first_pcol), 32'd2);
      chk("frame_err_count", 32'(seen_err), 32'd0);

      // sof on row 3 col 2 of a new frame restarts in the same cycle.
      line(8, 1'b1, 1'b1); line(8, 1'b0, 1'b1); line(8, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("midsof_we", 32'(obs_we), 32'h01);
      chk("midsof_re", 32'(obs_re), 32'h00);
      chk("midsof_addr", 32'(obs_addr), 32'd0);
      for (int c = 1; c < 8; c++) step(1'b1, 1'b0, c == 7);
      line(8, 1'b0, 1'b1);
      // Short line 2: still rotates.
      line(6, 1'b0, 1'b1);
      chk("short_err", 32'(bus.err_o), 32'd1);
      chk("short_nl", 32'(bus.lbx_nl_o), 32'd1);
      chk("short_ptr", 32'(bus.wr_ptr_o), 32'd3);
      // Missing eol: col 7 forces the line end.
      line(8, 1'b0, 1'b0);
      chk("forced_err", 32'(bus.err_o), 32'd1);
      chk("forced_ptr", 32'(bus.wr_ptr_o), 32'd4);
      // Asynchronous reset in the middle of a line.
      line(3, 1'b0, 1'b0);
      bus.intf_vld_i = 1'b1; bus.intf_sof_i = 1'b0; bus.intf_eol_i = 1'b0;
      arst_n = 1'b0; #1;
      chk_all_zero("midline_reset");
      bus.intf_vld_i = 1'b0;
      @(negedge clk) arst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
      seen_err = 0;
      step(1'b1, 1'b0, 1'b0);
      chk("nosof_we", 32'(obs_we), 32'd0);
      chk("nosof_err_count", 32'(seen_err), 32'd1);
      step(1'b0, 1'b0, 1'b0);
      chk("nosof_err_once", 32'(seen_err), 32'd1);

      // Randomized stream against the model.
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 1500; i++) begin
         step(($urandom % 8) != 0, ($urandom % 60) == 0, ($urandom % 6) == 0);
      end
      bus.intf_vld_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
